// File: rtl/ifu_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and the
// layout of the fetch-to-decode bus.
package ifu_fetch_stage_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  localparam int          IF_ID_BUS_W = 65;
  localparam int          ADEF_BIT    = 64;
  localparam int          PC_MSB      = 63;
  localparam int          PC_LSB      = 32;
  localparam logic [31:0] ADEF_INST   = 32'h0;

endpackage

// File: rtl/ifu_fetch_stage.sv
// Instruction-fetch stage: takes one PC from pre-fetch, issues a single SRAM
// read, buffers the word and hands {adef, pc, inst} to decode.
module ifu_fetch_stage
  import ifu_fetch_stage_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   preifu_to_ifu_valid,
  input  logic [PC_W-1:0]        pc_i,
  output logic                   ifu_allowin,
  input  logic                   flush_i,
  output logic                   inst_req,
  output logic [PC_W-1:0]        inst_addr,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [PC_W-1:0]        inst_rdata,
  output logic                   ifu_to_idu_valid,
  input  logic                   idu_allowin,
  output logic [IF_ID_BUS_W-1:0] ifu_to_idu_bus
);

  ifu_state_e      r_state, w_state_nxt;
  logic            r_cancel, w_cancel_nxt;
  logic [PC_W-1:0] r_pc, r_inst;
  logic            r_adef;
  logic            w_accept, w_misalign, w_data_keep;

  assign w_misalign  = (pc_i[1:0] != 2'b00);
  assign ifu_allowin = (r_state == IFU_IDLE && !r_cancel) ||
                       (r_state == IFU_HOLD && idu_allowin && !flush_i);
  assign w_accept    = preifu_to_ifu_valid && ifu_allowin;
  assign w_data_keep = (r_state == IFU_WAIT) && inst_data_ok && !r_cancel && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IFU_IDLE;
      r_cancel <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cancel <= w_cancel_nxt;
    end
  end

  // The request is never withdrawn once raised, so a flush in REQ only marks
  // the eventual response for discard.
  always_comb begin
    w_state_nxt  = r_state;
    w_cancel_nxt = r_cancel;
    case (r_state)
      IFU_IDLE: begin
        if (w_accept) w_state_nxt = w_misalign ? IFU_HOLD : IFU_REQ;
      end
      IFU_REQ: begin
        if (flush_i)      w_cancel_nxt = 1'b1;
        if (inst_addr_ok) w_state_nxt  = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (inst_data_ok) begin
          w_state_nxt  = (r_cancel || flush_i) ? IFU_IDLE : IFU_HOLD;
          w_cancel_nxt = 1'b0;
        end else if (flush_i) begin
          w_cancel_nxt = 1'b1;
        end
      end
      IFU_HOLD: begin
        if (flush_i)          w_state_nxt = IFU_IDLE;
        else if (idu_allowin) w_state_nxt = !w_accept ? IFU_IDLE :
                                            (w_misalign ? IFU_HOLD : IFU_REQ);
      end
      default: w_state_nxt = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= '0;
      r_inst <= '0;
      r_adef <= 1'b0;
    end else if (w_accept) begin
      r_pc   <= pc_i;
      r_adef <= w_misalign;
      if (w_misalign) r_inst <= ADEF_INST;
    end else if (w_data_keep) begin
      r_inst <= inst_rdata;
    end
  end

  assign inst_req         = (r_state == IFU_REQ);
  assign inst_addr        = inst_req ? r_pc : '0;
  assign ifu_to_idu_valid = (r_state == IFU_HOLD) && !flush_i;

  always_comb begin
    ifu_to_idu_bus                  = '0;
    ifu_to_idu_bus[ADEF_BIT]        = r_adef;
    ifu_to_idu_bus[PC_MSB:PC_LSB]   = r_pc;
    ifu_to_idu_bus[PC_LSB-1:0]      = r_inst;
  end

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Bench for ifu_fetch_stage: directed scenarios then random traffic, checked
// against a transaction-level model of the fetch slot and memory side.
module tb_ifu_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        preifu_to_ifu_valid;
  logic [31:0] pc_i;
  logic        ifu_allowin;
  logic        flush_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        ifu_to_idu_valid;
  logic        idu_allowin;
  logic [64:0] ifu_to_idu_bus;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: one fetch slot (pc, ready data) plus memory-side request tracking.
  bit          m_live, m_ready, m_adef, m_req, m_outst;
  logic [31:0] m_pc, m_inst, m_raddr;

  always #5 clk = ~clk;

  ifu_fetch_stage #(.PC_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .preifu_to_ifu_valid (preifu_to_ifu_valid),
    .pc_i                (pc_i),
    .ifu_allowin         (ifu_allowin),
    .flush_i             (flush_i),
    .inst_req            (inst_req),
    .inst_addr           (inst_addr),
    .inst_addr_ok        (inst_addr_ok),
    .inst_data_ok        (inst_data_ok),
    .inst_rdata          (inst_rdata),
    .ifu_to_idu_valid    (ifu_to_idu_valid),
    .idu_allowin         (idu_allowin),
    .ifu_to_idu_bus      (ifu_to_idu_bus)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_live = 0; m_ready = 0; m_adef = 0; m_req = 0; m_outst = 0;
    m_pc = '0; m_inst = '0; m_raddr = '0;
  endtask

  // One clock: drive at negedge, check against the model, advance at posedge.
  task automatic cyc(input bit v, input logic [31:0] pc, input bit fl, input bit ia,
                     input bit aok, input bit dok, input logic [31:0] rd);
    bit e_allow, e_valid, acc, mis;
    @(negedge clk);
    preifu_to_ifu_valid = v;   pc_i = pc;          flush_i = fl;
    idu_allowin = ia;          inst_addr_ok = aok; inst_data_ok = dok;
    inst_rdata = rd;
    #1;
    e_allow = !m_req && !m_outst && (!m_live || (m_ready && ia && !fl));
    e_valid = m_live && m_ready && !fl;
    chk("allowin",   65'(ifu_allowin),      65'(e_allow));
    chk("idu_valid", 65'(ifu_to_idu_valid), 65'(e_valid));
    chk("inst_req",  65'(inst_req),         65'(m_req));
    chk("inst_addr", 65'(inst_addr),        m_req ? 65'(m_raddr) : 65'd0);
    if (e_valid) chk("bus", ifu_to_idu_bus, {m_adef, m_pc, m_inst});
    acc = v && e_allow;
    @(posedge clk);
    if (m_outst && dok) begin
      m_outst = 0;
      if (m_live && !m_ready && !fl) begin
        m_ready = 1;
        m_inst  = rd;
      end
    end
    if (m_req && aok) begin
      m_req   = 0;
      m_outst = 1;
    end
    if (fl || (e_valid && ia)) m_live = 0;
    if (acc) begin
      mis    = (pc[1:0] != 2'b00);
      m_live = 1;
      m_pc   = pc;
      m_adef = mis;
      if (mis) begin
        m_ready = 1;
        m_inst  = 32'h0;
      end else begin
        m_ready = 0;
        m_req   = 1;
        m_raddr = pc;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          r_fl, r_v, r_ia, r_aok, r_dok;
    logic [31:0] r_pc;

    rst = 1'b1;
    preifu_to_ifu_valid = 0; pc_i = '0; flush_i = 0; idu_allowin = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_allowin",  65'(ifu_allowin),      65'd1);
    chk("rst_inst_req", 65'(inst_req),         65'd0);
    chk("rst_addr",     65'(inst_addr),        65'd0);
    chk("rst_valid",    65'(ifu_to_idu_valid), 65'd0);
    chk("rst_bus",      ifu_to_idu_bus,        65'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic fetch, best-case latency
    cyc(1, 32'h1c000000, 0, 1, 0, 0, 32'h0);
    #1;
    chk("first_req",  65'(inst_req),  65'd1);
    chk("first_addr", 65'(inst_addr), 65'h1c000000);
    cyc(0, 32'h0, 0, 1, 1, 0, 32'h0);
    cyc(0, 32'h0, 0, 1, 0, 1, 32'h02800000);
    #1;
    chk("first_bus",   ifu_to_idu_bus, {1'b0, 32'h1c000000, 32'h02800000});
    chk("first_valid", 65'(ifu_to_idu_valid), 65'd1);

    // Decode stall, then release with a new PC in the same cycle
    for (int k = 0; k < 5; k++) cyc(0, 32'h0, 0, 0, 0, 0, 32'h0);
    cyc(1, 32'h1c000040, 0, 1, 0, 0, 32'h0);
    #1;
    chk("overlap_req",  65'(inst_req),  65'd1);
    chk("overlap_addr", 65'(inst_addr), 65'h1c000040);

    // Flush in WAIT, late response dropped, then a clean fetch
    cyc(0, 32'h0, 0, 1, 1, 0, 32'h0);
    cyc(0, 32'h0, 1, 1, 0, 0, 32'h0);
    cyc(1, 32'h1c000100, 0, 1, 0, 0, 32'h0);
    cyc(1, 32'h1c000100, 0, 1, 0, 0, 32'h0);
    cyc(1, 32'h1c000100, 0, 1, 0, 1, 32'hDEADBEEF);
    cyc(1, 32'h1c000100, 0, 1, 0, 0, 32'h0);
    cyc(0, 32'h0, 0, 1, 1, 0, 32'h0);
    cyc(0, 32'h0, 0, 0, 0, 1, 32'h28c00004);
    #1;
    chk("post_flush_bus", ifu_to_idu_bus, {1'b0, 32'h1c000100, 32'h28c00004});
    cyc(0, 32'h0, 0, 1, 0, 0, 32'h0);

    // Flush in REQ with delayed addr_ok
    cyc(1, 32'h1c000200, 0, 1, 0, 0, 32'h0);
    cyc(0, 32'h0, 1, 1, 0, 0, 32'h0);
    cyc(0, 32'h0, 0, 1, 0, 0, 32'h0);
    cyc(0, 32'h0, 0, 1, 1, 0, 32'h0);
    cyc(0, 32'h0, 0, 1, 0, 1, 32'h12345678);
    #1;
    chk("req_flush_allowin", 65'(ifu_allowin),      65'd1);
    chk("req_flush_valid",   65'(ifu_to_idu_valid), 65'd0);

    // Misaligned PC, then flush in HOLD with decode ready
    cyc(1, 32'h1c000002, 0, 0, 0, 0, 32'h0);
    #1;
    chk("adef_req", 65'(inst_req),  65'd0);
    chk("adef_bus", ifu_to_idu_bus, {1'b1, 32'h1c000002, 32'h0});
    cyc(0, 32'h0, 1, 1, 0, 0, 32'h0);
    #1;
    chk("hold_flush_allowin", 65'(ifu_allowin),      65'd1);
    chk("hold_flush_valid",   65'(ifu_to_idu_valid), 65'd0);

    // Random traffic with a well-behaved memory responder
    for (int i = 0; i < 3000; i++) begin
      r_fl  = ($urandom_range(0, 11) == 0);
      r_v   = !r_fl && ($urandom_range(0, 1) == 1);
      r_pc  = $urandom & 32'hffff_fffc;
      if ($urandom_range(0, 5) == 0) r_pc[1:0] = 2'($urandom_range(1, 3));
      r_ia  = ($urandom_range(0, 3) != 0);
      r_aok = m_req && ($urandom_range(0, 1) == 1);
      r_dok = m_outst && ($urandom_range(0, 2) == 0);
      cyc(r_v, r_pc, r_fl, r_ia, r_aok, r_dok, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
